// File: rtl/message_to_packet_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : message_to_packet_queue_pkg
//  Description : Shared NIC widths, flit type codes, head-flit field layout and
//                the flit-count helper used by the message-to-packet queue.
//  Revision    : 1.0  initial release
// ============================================================================
package message_to_packet_queue_pkg;

    localparam int FLIT_WIDTH        = 32;
    localparam int BUS_ADDRESS_WIDTH = 24;
    localparam int BUS_TGA_WIDTH     = 4;
    localparam int BUS_TGC_WIDTH     = 2;
    localparam int BUS_DATA_WIDTH    = 32;
    localparam int QUEUE_WIDTH       = 8;
    localparam int MAX_BURST_LENGHT  = 8;
    localparam int MAX_PACKET_LENGHT = 1 + (MAX_BURST_LENGHT * BUS_DATA_WIDTH + FLIT_WIDTH - 1) / FLIT_WIDTH;
    localparam int LINK_WIDTH        = MAX_PACKET_LENGHT * FLIT_WIDTH;

    // Flit type codes
    localparam int          FLIT_TYPE_WIDTH = 2;
    localparam logic [1:0]  BODY_FLIT       = 2'b00;
    localparam logic [1:0]  TAIL_FLIT       = 2'b01;
    localparam logic [1:0]  HEAD_FLIT       = 2'b10;
    localparam logic [1:0]  HEAD_TAIL_FLIT  = 2'b11;

    // Head flit layout: {type, src, cmd, address}
    localparam int HEAD_FLIT_ADDRESS_LSB = 0;
    localparam int CMD_BITS_HEAD_LSB     = HEAD_FLIT_ADDRESS_LSB + BUS_ADDRESS_WIDTH;
    localparam int SRC_BITS_HEAD_LSB     = CMD_BITS_HEAD_LSB + BUS_TGC_WIDTH;
    localparam int FLIT_TYPE_LSB         = SRC_BITS_HEAD_LSB + BUS_TGA_WIDTH;

    // Bus command tags
    localparam logic [1:0] CMD_READ  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    // Number of flits needed to carry a given number of bus chunks (ceil division)
    function automatic int flit_count(input int chunks);
        return (chunks * BUS_DATA_WIDTH + FLIT_WIDTH - 1) / FLIT_WIDTH;
    endfunction

endpackage
`default_nettype wire

// File: rtl/message_to_packet_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : message_to_packet_queue_if
//  Description : Bus-side message inputs and packet-side request/grant port
//                of the message-to-packet queue.
//  Revision    : 1.0  initial release
// ============================================================================
interface message_to_packet_queue_if;
    import message_to_packet_queue_pkg::*;

    logic                         start_msg_i;
    logic [BUS_ADDRESS_WIDTH-1:0] address_i;
    logic [BUS_TGA_WIDTH-1:0]     tga_i;
    logic [BUS_TGC_WIDTH-1:0]     tgc_i;
    logic [BUS_DATA_WIDTH-1:0]    data_i;
    logic                         data_valid_i;
    logic                         last_i;
    logic                         abort_i;
    logic                         stall_msg_to_pkt_o;
    logic                         overflow_o;
    logic [LINK_WIDTH-1:0]        out_link_o;
    logic [MAX_PACKET_LENGHT-1:0] out_sel_o;
    logic                         r_msg_to_pkt_o;
    logic                         g_msg_to_pkt_i;

    modport master (
        output start_msg_i, address_i, tga_i, tgc_i, data_i, data_valid_i,
               last_i, abort_i, g_msg_to_pkt_i,
        input  stall_msg_to_pkt_o, overflow_o, out_link_o, out_sel_o, r_msg_to_pkt_o
    );

    modport slave (
        input  start_msg_i, address_i, tga_i, tgc_i, data_i, data_valid_i,
               last_i, abort_i, g_msg_to_pkt_i,
        output stall_msg_to_pkt_o, overflow_o, out_link_o, out_sel_o, r_msg_to_pkt_o
    );
endinterface
`default_nettype wire

// File: rtl/message_to_packet_queue_head_flit_builder.sv
`default_nettype none
// ============================================================================
//  Module      : message_to_packet_queue_head_flit_builder
//  Description : Combinational head flit assembly from the captured bus
//                fields and the final chunk count of a message.
//  Revision    : 1.0  initial release
// ============================================================================
module message_to_packet_queue_head_flit_builder
    import message_to_packet_queue_pkg::*;
#(
    parameter int N_BITS_BURST_LENGHT = 7
) (
    input  wire logic [BUS_ADDRESS_WIDTH-1:0]   i_address,
    input  wire logic [BUS_TGA_WIDTH-1:0]       i_tga,
    input  wire logic [BUS_TGC_WIDTH-1:0]       i_tgc,
    input  wire logic [N_BITS_BURST_LENGHT-1:0] i_chunks,
    output logic      [FLIT_WIDTH-1:0]          o_head_flit
);

    // A message without data is a single head+tail flit
    always_comb begin
        o_head_flit = '0;
        o_head_flit[FLIT_TYPE_LSB +: FLIT_TYPE_WIDTH] = (i_chunks == '0) ? HEAD_TAIL_FLIT : HEAD_FLIT;
        o_head_flit[SRC_BITS_HEAD_LSB +: BUS_TGA_WIDTH]         = i_tga;
        o_head_flit[CMD_BITS_HEAD_LSB +: BUS_TGC_WIDTH]         = i_tgc;
        o_head_flit[HEAD_FLIT_ADDRESS_LSB +: BUS_ADDRESS_WIDTH] = i_address;
    end

endmodule
`default_nettype wire

// File: rtl/message_to_packet_queue.sv
`default_nettype none
// ============================================================================
//  Module      : message_to_packet_queue
//  Description : Assembles bus messages chunk by chunk into a FIFO of packet
//                slots and offers the oldest complete packet with req/grant.
//  Revision    : 1.0  initial release
// ============================================================================
module message_to_packet_queue
    import message_to_packet_queue_pkg::*;
#(
    parameter int N_BITS_POINTER      = 3,
    parameter int N_BITS_BURST_LENGHT = 7
) (
    input  wire logic               clk,
    input  wire logic               rst,
    message_to_packet_queue_if.slave bus
);

    localparam int CHUNK_IDX_W = $clog2(MAX_BURST_LENGHT);
    localparam logic [N_BITS_POINTER-1:0]      PTR_LAST  = N_BITS_POINTER'(QUEUE_WIDTH - 1);
    localparam logic [N_BITS_BURST_LENGHT-1:0] CNT_LIMIT = N_BITS_BURST_LENGHT'(MAX_BURST_LENGHT);

    state_t                         state_q, state_d;
    logic [N_BITS_POINTER-1:0]      tail_q, tail_d, head_q, head_d;
    logic [QUEUE_WIDTH-1:0]         valid_q, valid_d;
    logic [N_BITS_BURST_LENGHT-1:0] cnt_q, cnt_d;
    logic                           overflow_q, overflow_d;

    // Slot storage (not reset)
    logic [BUS_ADDRESS_WIDTH-1:0]   slot_addr [QUEUE_WIDTH];
    logic [BUS_TGA_WIDTH-1:0]       slot_tga  [QUEUE_WIDTH];
    logic [BUS_TGC_WIDTH-1:0]       slot_tgc  [QUEUE_WIDTH];
    logic [N_BITS_BURST_LENGHT-1:0] slot_cnt  [QUEUE_WIDTH];
    logic [BUS_DATA_WIDTH-1:0]      slot_data [QUEUE_WIDTH][MAX_BURST_LENGHT];

    logic                           w_stall, w_start, w_active, w_room;
    logic                           w_take, w_drop, w_complete, w_deq;
    logic [N_BITS_BURST_LENGHT-1:0] w_cur_cnt, w_final_cnt;

    // Message acceptance and chunk bookkeeping for the current cycle
    always_comb begin
        w_stall     = valid_q[tail_q];
        w_start     = (state_q == ST_IDLE) && bus.start_msg_i && !w_stall;
        w_active    = (state_q == ST_COLLECT) || w_start;
        w_cur_cnt   = (state_q == ST_IDLE) ? '0 : cnt_q;
        w_room      = (w_cur_cnt < CNT_LIMIT);
        w_take      = w_active && !bus.abort_i && bus.data_valid_i && w_room;
        w_drop      = w_active && !bus.abort_i && bus.data_valid_i && !w_room;
        w_complete  = w_active && !bus.abort_i && bus.last_i;
        w_deq       = bus.g_msg_to_pkt_i && valid_q[head_q];
        w_final_cnt = w_cur_cnt + N_BITS_BURST_LENGHT'(w_take);
    end

    // Next-state for the FSM, FIFO pointers, valid bits and overflow flag
    always_comb begin
        state_d    = state_q;
        tail_d     = tail_q;
        head_d     = head_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        if (w_start) begin
            overflow_d = 1'b0;
        end
        if (w_drop) begin
            overflow_d = 1'b1;
        end
        if (w_active) begin
            if (bus.abort_i || bus.last_i) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                state_d = ST_COLLECT;
                cnt_d   = w_final_cnt;
            end
        end
        if (w_complete) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = (tail_q == PTR_LAST) ? '0 : tail_q + 1'b1;
        end
        // The head slot is never the one being assembled, so this cannot collide
        if (w_deq) begin
            valid_d[head_q] = 1'b0;
            head_d          = (head_q == PTR_LAST) ? '0 : head_q + 1'b1;
        end
    end

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tail_q     <= '0;
            head_q     <= '0;
            valid_q    <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tail_q     <= tail_d;
            head_q     <= head_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Slot writes: header fields at start, chunks as they arrive, count at last
    always_ff @(posedge clk) begin
        if (w_start) begin
            slot_addr[tail_q] <= bus.address_i;
            slot_tga[tail_q]  <= bus.tga_i;
            slot_tgc[tail_q]  <= bus.tgc_i;
        end
        if (w_take) begin
            slot_data[tail_q][w_cur_cnt[CHUNK_IDX_W-1:0]] <= bus.data_i;
        end
        if (w_complete) begin
            slot_cnt[tail_q] <= w_final_cnt;
        end
    end

    logic [FLIT_WIDTH-1:0]        w_head_flit;
    logic [LINK_WIDTH-1:0]        w_raw, w_link;
    logic [MAX_PACKET_LENGHT-1:0] w_sel;
    int                           w_n_flits;

    message_to_packet_queue_head_flit_builder #(
        .N_BITS_BURST_LENGHT (N_BITS_BURST_LENGHT)
    ) u_head_flit_builder (
        .i_address   (slot_addr[head_q]),
        .i_tga       (slot_tga[head_q]),
        .i_tgc       (slot_tgc[head_q]),
        .i_chunks    (slot_cnt[head_q]),
        .o_head_flit (w_head_flit)
    );

    // Valid-flit mask: head flit plus the flits carrying the stored chunks
    always_comb begin
        w_n_flits = flit_count(int'(slot_cnt[head_q]));
        w_sel     = '0;
        for (int i = 0; i < MAX_PACKET_LENGHT; i++) begin
            w_sel[i] = (i <= w_n_flits);
        end
    end

    assign w_raw[FLIT_WIDTH-1:0] = w_head_flit;

    generate
        for (genvar c = 0; c < MAX_BURST_LENGHT; c++) begin : g_chunk
            assign w_raw[FLIT_WIDTH + c*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = slot_data[head_q][c];
        end
        for (genvar f = 0; f < MAX_PACKET_LENGHT; f++) begin : g_mask
            assign w_link[f*FLIT_WIDTH +: FLIT_WIDTH] = w_sel[f] ? w_raw[f*FLIT_WIDTH +: FLIT_WIDTH] : '0;
        end
    endgenerate

    assign bus.stall_msg_to_pkt_o = w_stall;
    assign bus.overflow_o         = overflow_q;
    assign bus.r_msg_to_pkt_o     = valid_q[head_q];
    assign bus.out_link_o         = w_link;
    assign bus.out_sel_o          = w_sel;

endmodule
`default_nettype wire

// File: tb/tb_message_to_packet_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_message_to_packet_queue
//  Description : Self-checking bench for message_to_packet_queue with a
//                packet-level FIFO reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_message_to_packet_queue;
    import message_to_packet_queue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    message_to_packet_queue_if bus ();

    message_to_packet_queue #(
        .N_BITS_POINTER      (3),
        .N_BITS_BURST_LENGHT (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [BUS_ADDRESS_WIDTH-1:0]        addr;
        logic [BUS_TGA_WIDTH-1:0]            tga;
        logic [BUS_TGC_WIDTH-1:0]            tgc;
        int                                  n;
        logic [MAX_BURST_LENGHT-1:0][BUS_DATA_WIDTH-1:0] d;
    } pkt_t;

    typedef struct packed {
        logic [BUS_ADDRESS_WIDTH-1:0] addr;
        logic [BUS_TGA_WIDTH-1:0]     tga;
        logic [BUS_TGC_WIDTH-1:0]     tgc;
        int                           n;
        logic [1:0]                   ty;
        logic [MAX_PACKET_LENGHT-1:0] sel;
    } vec_t;

    int   n_pass = 0;
    int   n_total = 0;
    pkt_t q[$];
    pkt_t cur;
    bit   coll;
    bit   m_ovf;

    task automatic chk(input string name, input logic [LINK_WIDTH-1:0] act, input logic [LINK_WIDTH-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [LINK_WIDTH-1:0] exp_link(input pkt_t p);
        logic [LINK_WIDTH-1:0] v;
        logic [1:0] ty;
        v  = '0;
        ty = (p.n == 0) ? HEAD_TAIL_FLIT : HEAD_FLIT;
        v[FLIT_WIDTH-1:0] = {ty, p.tga, p.tgc, p.addr};
        for (int i = 0; i < p.n; i++) v[FLIT_WIDTH*(i+1) +: BUS_DATA_WIDTH] = p.d[i];
        return v;
    endfunction

    function automatic logic [MAX_PACKET_LENGHT-1:0] exp_sel(input int n);
        logic [MAX_PACKET_LENGHT-1:0] s;
        int nf;
        nf = (n * BUS_DATA_WIDTH + FLIT_WIDTH - 1) / FLIT_WIDTH;
        s  = '0;
        for (int i = 0; i <= nf; i++) s[i] = 1'b1;
        return s;
    endfunction

    task automatic idle();
        bus.start_msg_i    = 1'b0;
        bus.data_valid_i   = 1'b0;
        bus.last_i         = 1'b0;
        bus.abort_i        = 1'b0;
        bus.g_msg_to_pkt_i = 1'b0;
    endtask

    // One clock: advance the model with the driven inputs, then compare
    task automatic cyc();
        bit stall_e, act, push;
        push    = 1'b0;
        stall_e = (q.size() == QUEUE_WIDTH);
        act     = coll || (bus.start_msg_i && !stall_e);
        if (!coll && bus.start_msg_i && !stall_e) begin
            cur      = '0;
            cur.addr = bus.address_i;
            cur.tga  = bus.tga_i;
            cur.tgc  = bus.tgc_i;
            m_ovf    = 1'b0;
        end
        if (act) begin
            if (bus.abort_i) coll = 1'b0;
            else begin
                if (bus.data_valid_i) begin
                    if (cur.n < MAX_BURST_LENGHT) begin
                        cur.d[cur.n] = bus.data_i;
                        cur.n++;
                    end else m_ovf = 1'b1;
                end
                if (bus.last_i) begin
                    push = 1'b1;
                    coll = 1'b0;
                end else coll = 1'b1;
            end
        end
        if (bus.g_msg_to_pkt_i && q.size() > 0) void'(q.pop_front());
        if (push) q.push_back(cur);
        @(posedge clk);
        #1;
        chk("stall", bus.stall_msg_to_pkt_o, q.size() == QUEUE_WIDTH);
        chk("r", bus.r_msg_to_pkt_o, q.size() > 0);
        chk("overflow", bus.overflow_o, m_ovf);
        if (q.size() > 0) begin
            chk("out_sel", bus.out_sel_o, exp_sel(q[0].n));
            chk("out_link", bus.out_link_o, exp_link(q[0]));
        end
    endtask

    task automatic reset_dut();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        coll  = 1'b0;
        m_ovf = 1'b0;
    endtask

    // n chunks of value base+k; chunk 0 rides on the start cycle; last on the final chunk
    task automatic send_msg(input logic [BUS_ADDRESS_WIDTH-1:0] a, input logic [BUS_TGA_WIDTH-1:0] t,
                            input logic [BUS_TGC_WIDTH-1:0] c, input int n, input logic [31:0] base,
                            input bit g_on_last);
        bus.start_msg_i  = 1'b1;
        bus.address_i    = a;
        bus.tga_i        = t;
        bus.tgc_i        = c;
        bus.data_valid_i = (n > 0);
        bus.data_i       = base;
        bus.last_i       = (n <= 1);
        bus.g_msg_to_pkt_i = g_on_last && (n <= 1);
        cyc();
        bus.start_msg_i = 1'b0;
        for (int k = 1; k < n; k++) begin
            bus.data_valid_i   = 1'b1;
            bus.data_i         = base + 32'(k);
            bus.last_i         = (k == n - 1);
            bus.g_msg_to_pkt_i = g_on_last && (k == n - 1);
            cyc();
        end
        idle();
    endtask

    vec_t tbl [5];

    initial begin
        tbl[0] = '{addr: 24'h000040, tga: 4'd3,  tgc: CMD_WRITE, n: 4, ty: HEAD_FLIT,      sel: 9'h01F};
        tbl[1] = '{addr: 24'h123456, tga: 4'd5,  tgc: CMD_READ,  n: 0, ty: HEAD_TAIL_FLIT, sel: 9'h001};
        tbl[2] = '{addr: 24'hABCDEF, tga: 4'd15, tgc: CMD_WRITE, n: 1, ty: HEAD_FLIT,      sel: 9'h003};
        tbl[3] = '{addr: 24'h000000, tga: 4'd0,  tgc: 2'd2,      n: 8, ty: HEAD_FLIT,      sel: 9'h1FF};
        tbl[4] = '{addr: 24'hFFFFFF, tga: 4'd9,  tgc: 2'd3,      n: 7, ty: HEAD_FLIT,      sel: 9'h0FF};

        idle();
        bus.address_i = '0;
        bus.tga_i     = '0;
        bus.tgc_i     = '0;
        bus.data_i    = '0;
        reset_dut();
        chk("reset_r", bus.r_msg_to_pkt_o, 1'b0);
        chk("reset_stall", bus.stall_msg_to_pkt_o, 1'b0);
        chk("reset_overflow", bus.overflow_o, 1'b0);

        // Table of single messages: check type, mask and chunks, then grant
        for (int i = 0; i < 5; i++) begin
            logic [31:0] base;
            base = 32'hA + (32'(i) << 16);
            send_msg(tbl[i].addr, tbl[i].tga, tbl[i].tgc, tbl[i].n, base, 1'b0);
            chk("tbl_r", bus.r_msg_to_pkt_o, 1'b1);
            chk("tbl_type", bus.out_link_o[FLIT_TYPE_LSB +: 2], tbl[i].ty);
            chk("tbl_sel", bus.out_sel_o, tbl[i].sel);
            for (int k = 0; k < tbl[i].n; k++)
                chk("tbl_chunk", bus.out_link_o[FLIT_WIDTH*(k+1) +: 32], base + 32'(k));
            bus.g_msg_to_pkt_i = 1'b1;
            cyc();
            idle();
            chk("tbl_r_after_grant", bus.r_msg_to_pkt_o, 1'b0);
        end

        // Full queue, stalled start ignored, wrap into slot 0
        reset_dut();
        for (int i = 0; i < 8; i++) send_msg(24'(i + 1), 4'd1, CMD_READ, 0, 32'h0, 1'b0);
        chk("full_stall", bus.stall_msg_to_pkt_o, 1'b1);
        bus.start_msg_i = 1'b1;
        bus.address_i   = 24'h99;
        bus.last_i      = 1'b1;
        cyc();
        idle();
        chk("full_ignored_head", bus.out_link_o[23:0], 24'h1);
        bus.g_msg_to_pkt_i = 1'b1;
        cyc();
        idle();
        chk("full_stall_released", bus.stall_msg_to_pkt_o, 1'b0);
        send_msg(24'h99, 4'd2, CMD_WRITE, 2, 32'h900, 1'b0);
        chk("wrap_stall", bus.stall_msg_to_pkt_o, 1'b1);
        for (int i = 0; i < 8; i++) begin
            bus.g_msg_to_pkt_i = 1'b1;
            cyc();
        end
        idle();
        chk("drained", bus.r_msg_to_pkt_o, 1'b0);

        // Completion and grant in the same cycle with 7 complete + 1 assembling
        reset_dut();
        for (int i = 0; i < 7; i++) send_msg(24'(i + 16), 4'd4, CMD_READ, 0, 32'h0, 1'b0);
        send_msg(24'h77, 4'd7, CMD_WRITE, 2, 32'h770, 1'b1);
        chk("simul_stall", bus.stall_msg_to_pkt_o, 1'b0);
        chk("simul_head", bus.out_link_o[23:0], 24'h11);
        for (int i = 0; i < 7; i++) begin
            bus.g_msg_to_pkt_i = 1'b1;
            cyc();
        end
        idle();
        chk("simul_drained", bus.r_msg_to_pkt_o, 1'b0);

        // Abort after two chunks, then reuse of the same slot
        reset_dut();
        bus.start_msg_i  = 1'b1;
        bus.address_i    = 24'h333;
        bus.data_valid_i = 1'b1;
        bus.data_i       = 32'hDEAD0;
        cyc();
        bus.start_msg_i = 1'b0;
        bus.data_i      = 32'hDEAD1;
        cyc();
        bus.data_valid_i = 1'b0;
        bus.abort_i      = 1'b1;
        bus.last_i       = 1'b1;
        cyc();
        idle();
        chk("abort_no_r", bus.r_msg_to_pkt_o, 1'b0);
        send_msg(24'h444, 4'd6, CMD_WRITE, 1, 32'h55, 1'b0);
        chk("abort_reuse_sel", bus.out_sel_o, 9'h003);
        chk("abort_reuse_data", bus.out_link_o[63:32], 32'h55);
        bus.g_msg_to_pkt_i = 1'b1;
        cyc();
        idle();

        // Overflow: one chunk beyond the burst limit is dropped
        send_msg(24'h555, 4'd8, CMD_WRITE, MAX_BURST_LENGHT + 1, 32'h100, 1'b0);
        chk("overflow_set", bus.overflow_o, 1'b1);
        chk("overflow_sel", bus.out_sel_o, 9'h1FF);
        chk("overflow_last_kept", bus.out_link_o[FLIT_WIDTH*8 +: 32], 32'h107);

        // Asynchronous reset in the middle of a message
        bus.start_msg_i  = 1'b1;
        bus.address_i    = 24'h666;
        bus.data_valid_i = 1'b1;
        bus.data_i       = 32'h1;
        cyc();
        idle();
        #2;
        rst = 1'b1;
        #1;
        chk("async_r", bus.r_msg_to_pkt_o, 1'b0);
        chk("async_stall", bus.stall_msg_to_pkt_o, 1'b0);
        chk("async_overflow", bus.overflow_o, 1'b0);
        q.delete();
        coll  = 1'b0;
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.data_valid_i = 1'b1;
        bus.last_i       = 1'b1;
        cyc();
        idle();
        chk("async_no_packet", bus.r_msg_to_pkt_o, 1'b0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            bus.start_msg_i    = ($urandom % 3 == 0);
            bus.address_i      = 24'($urandom);
            bus.tga_i          = 4'($urandom);
            bus.tgc_i          = 2'($urandom);
            bus.data_i         = $urandom;
            bus.data_valid_i   = ($urandom % 2 == 0);
            bus.last_i         = coll ? ($urandom % 6 == 0) : ($urandom % 3 == 0);
            bus.abort_i        = ($urandom % 30 == 0);
            bus.g_msg_to_pkt_i = ($urandom % 5 < 2);
            cyc();
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
